gray_bin_pipe: RTL and testbench

//  Parametrised, registered Gray<->binary code converter with valid/ready handshake on both sides.
//  Per-transfer mode selects Gray->binary or binary->Gray.
//  In Gray->binary mode it checks that successive Gray inputs differ in at most one bit.

---
 rtl/gray_bin_pipe.sv | 105 ++++++++++
 tb/tb_gray_bin_pipe.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_bin_pipe.sv
// Registered Gray<->binary converter, valid/ready on both sides,
// with optional Gray adjacency check and saturating error count.
//
// Ports:
//   clk, rst            rising-edge clock, sync active-high reset
//   in_valid/in_ready   input handshake
//   in_mode             0 = Gray->binary, 1 = binary->Gray
//   in_data             input code
//   out_valid/out_ready output handshake
//   out_mode            mode of the word held in the output register
//   out_data            converted code
//   out_err             adjacency violation for this output word
//   err_cnt             saturating count of adjacency violations
module gray_bin_pipe #(
   parameter int WIDTH     = 4,
   parameter int CHECK_ADJ = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_mode,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt
);

   logic             accept;
   logic             pop;
   logic [WIDTH-1:0] g2b;
   logic [WIDTH-1:0] b2g;
   logic [WIDTH-1:0] conv;
   logic [WIDTH-1:0] last_gray;
   logic             hist_vld;
   logic [WIDTH-1:0] diff;
   logic             multi;
   logic             adj_viol;
   logic             cnt_sat;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   // Binary bit i is the XOR of all Gray bits at or above i.
   always_comb begin
      g2b = '0;
      for (int i = 0; i < WIDTH; i++) begin
         g2b[i] = ^(in_data >> i);
      end
   end

   assign b2g  = in_data ^ (in_data >> 1);
   assign conv = in_mode ? b2g : g2b;

   // More than one bit set <=> clearing the lowest set bit leaves
   // something behind.
   assign diff  = in_data ^ last_gray;
   assign multi = |(diff & (diff - WIDTH'(1)));

   assign adj_viol = (CHECK_ADJ != 0) && hist_vld &&
                     !in_mode && multi;

   assign cnt_sat = &err_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_mode  <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_mode  <= in_mode;
         out_data  <= conv;
         out_err   <= adj_viol;
      end else if (pop) begin
         out_valid <= 1'b0;
      end
   end

   // History only tracks Gray-mode traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_vld  <= 1'b0;
         last_gray <= '0;
      end else if (accept && !in_mode) begin
         hist_vld  <= 1'b1;
         last_gray <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (accept && adj_viol && !cnt_sat) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_gray_bin_pipe.sv
// Self-checking bench for gray_bin_pipe: conversion, streaming,
// adjacency, backpressure, saturation and mid-stream reset.
module tb_gray_bin_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, in_mode;
   logic [3:0] in_data;
   logic       out_valid, out_ready, out_mode;
   logic [3:0] out_data;
   logic       out_err;
   logic [7:0] err_cnt;

   logic       s_in_valid, s_in_ready, s_in_mode;
   logic [3:0] s_in_data;
   logic       s_out_valid, s_out_ready, s_out_mode;
   logic [3:0] s_out_data;
   logic       s_out_err;
   logic [1:0] s_err_cnt;

   int checks = 0;
   int failures = 0;

   bit         m_hist;
   logic [3:0] m_last;
   int         m_cnt;

   typedef struct {
      logic [3:0] d;
      bit         m;
      bit         e;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   gray_bin_pipe #(.WIDTH(4), .CHECK_ADJ(1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mode(out_mode), .out_data(out_data),
      .out_err(out_err), .err_cnt(err_cnt)
   );

   gray_bin_pipe #(.WIDTH(4), .CHECK_ADJ(1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_mode(s_in_mode), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_mode(s_out_mode), .out_data(s_out_data),
      .out_err(s_out_err), .err_cnt(s_err_cnt)
   );

   // Inverse Gray by search: the binary b whose Gray code is g.
   function automatic logic [3:0] ref_g2b(input logic [3:0] g);
      logic [3:0] r = '0;
      for (int b = 0; b < 16; b++) begin
         if (4'(b ^ (b >> 1)) == g) r = 4'(b);
      end
      return r;
   endfunction

   function automatic logic [3:0] ref_b2g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_accept(input bit mode, input logic [3:0] d,
                               output logic [3:0] ed, output bit ee);
      ee = 1'b0;
      if (mode) begin
         ed = ref_b2g(d);
      end else begin
         ed = ref_g2b(d);
         if (m_hist && $countones(d ^ m_last) > 1) begin
            ee = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
         m_hist = 1'b1;
         m_last = d;
      end
   endtask

   task automatic model_reset();
      m_hist = 1'b0;
      m_last = '0;
      m_cnt  = 0;
      q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      s_in_valid = 1'b0;
      s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic push(input bit mode, input logic [3:0] d);
      in_valid = 1'b1;
      in_mode = mode;
      in_data = d;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data = 4'($urandom);
      in_mode = 1'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_mode = 1'b1;
      in_data = 4'hf;
      out_ready = 1'b0;
      s_in_valid = 1'b0;
      s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 ||
          out_mode !== 1'b0 || out_err !== 1'b0 ||
          err_cnt !== 8'h0) begin
         failures++;
         $display("FAIL reset v=%b d=%h m=%b e=%b c=%0d required 0",
                  out_valid, out_data, out_mode, out_err, err_cnt);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      model_reset();
   endtask

   task automatic test_convert();
      logic [3:0] ed, b;
      bit ee;
      do_reset();
      push(1'b0, 4'b1101);
      model_accept(1'b0, 4'b1101, ed, ee);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'b1001) begin
         failures++;
         $display("FAIL conv_m0 v=%b d=%b exp v=1 d=1001",
                  out_valid, out_data);
      end
      push(1'b1, 4'b1001);
      model_accept(1'b1, 4'b1001, ed, ee);
      checks++;
      if (out_mode !== 1'b1 || out_data !== 4'b1101) begin
         failures++;
         $display("FAIL conv_m1 m=%b d=%b exp m=1 d=1101",
                  out_mode, out_data);
      end
      for (int c = 0; c < 16; c++) begin
         push(1'b0, 4'(c));
         model_accept(1'b0, 4'(c), ed, ee);
         checks++;
         if (out_data !== ed || out_err !== ee ||
             err_cnt !== 8'(m_cnt)) begin
            failures++;
            $display("FAIL sweep_g2b c=%h d=%h e=%b n=%0d exp %h %b %0d",
                     c, out_data, out_err, err_cnt, ed, ee, m_cnt);
         end
         b = out_data;
         push(1'b1, b);
         model_accept(1'b1, b, ed, ee);
         checks++;
         if (out_data !== 4'(c) || out_err !== 1'b0) begin
            failures++;
            $display("FAIL trip_gbg c=%h got=%h e=%b", c, out_data,
                     out_err);
         end
         push(1'b1, 4'(c));
         model_accept(1'b1, 4'(c), ed, ee);
         checks++;
         if (out_data !== ed || out_mode !== 1'b1) begin
            failures++;
            $display("FAIL sweep_b2g c=%h got=%h exp=%h", c,
                     out_data, ed);
         end
      end
   endtask

   task automatic test_streaming();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_mode = 1'b0;
         in_data = ref_b2g(4'(i));
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 4'(i) ||
             out_err !== 1'b0 || err_cnt !== 8'h0) begin
            failures++;
            $display("FAIL stream i=%0d v=%b d=%h e=%b c=%0d",
                     i, out_valid, out_data, out_err, err_cnt);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_adjacency();
      do_reset();
      push(1'b0, 4'b0000);
      checks++;
      if (out_err !== 1'b0 || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL adj_first e=%b c=%0d exp 0 0", out_err, err_cnt);
      end
      push(1'b0, 4'b0011);
      checks++;
      if (out_err !== 1'b1 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL adj_viol e=%b c=%0d exp 1 1", out_err, err_cnt);
      end
      push(1'b1, 4'b1111);
      checks++;
      if (out_err !== 1'b0 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL adj_mode1 e=%b c=%0d exp 0 1", out_err, err_cnt);
      end
      push(1'b0, 4'b0011);
      checks++;
      if (out_err !== 1'b0 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL adj_repeat e=%b c=%0d exp 0 1", out_err, err_cnt);
      end
      push(1'b0, 4'b0010);
      checks++;
      if (out_err !== 1'b0 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL adj_dist1 e=%b c=%0d exp 0 1", out_err, err_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] ea, eb;
      bit ee;
      do_reset();
      in_valid = 1'b1;
      in_mode = 1'b0;
      in_data = 4'b0110;
      out_ready = 1'b0;
      model_accept(1'b0, 4'b0110, ea, ee);
      @(posedge clk);
      #1;
      in_data = 4'b0111;
      in_mode = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
             out_data !== ea) begin
            failures++;
            $display("FAIL stall k=%0d rdy=%b v=%b d=%h exp 0 1 %h",
                     k, in_ready, out_valid, out_data, ea);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      model_accept(1'b0, 4'b0111, eb, ee);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== eb || out_err !== ee) begin
         failures++;
         $display("FAIL release v=%b d=%h e=%b exp 1 %h %b",
                  out_valid, out_data, out_err, eb, ee);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL no_dup v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_random_stream();
      exp_t e;
      exp_t f;
      int guard;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         in_valid = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_mode = 1'($urandom);
         in_data = ($urandom_range(0, 1) != 0) ? 4'($urandom) :
                   (m_last ^ (4'b1 << $urandom_range(0, 3)));
         #1;
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            failures++;
            $display("FAIL rnd_ready n=%0d got=%b", n, in_ready);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL rnd_dup n=%0d unexpected d=%h", n,
                        out_data);
            end else begin
               f = q.pop_front();
               if (out_data !== f.d || out_mode !== f.m ||
                   out_err !== f.e) begin
                  failures++;
                  $display("FAIL rnd_word n=%0d got %h %b %b exp %h %b %b",
                           n, out_data, out_mode, out_err, f.d, f.m, f.e);
               end
            end
         end
         if (in_valid && in_ready) begin
            model_accept(in_mode, in_data, e.d, e.e);
            e.m = in_mode;
            q.push_back(e);
         end
         @(posedge clk);
         #1;
         checks++;
         if (err_cnt !== 8'(m_cnt)) begin
            failures++;
            $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, err_cnt,
                     m_cnt);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         #1;
         if (out_valid) begin
            f = q.pop_front();
            checks++;
            if (out_data !== f.d || out_mode !== f.m ||
                out_err !== f.e) begin
               failures++;
               $display("FAIL rnd_drain got %h exp %h", out_data, f.d);
            end
         end
         @(posedge clk);
         #1;
         guard++;
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL rnd_lost left=%0d exp=0", q.size());
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt [6];
      bit         exp_err [6];
      exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      exp_err = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         s_in_valid = 1'b1;
         s_in_mode = 1'b0;
         s_in_data = (i % 2 == 0) ? 4'b0000 : 4'b1111;
         s_out_ready = 1'b1;
         @(posedge clk);
         #1;
         checks++;
         if (s_out_valid !== 1'b1 || s_err_cnt !== exp_cnt[i] ||
             s_out_err !== exp_err[i]) begin
            failures++;
            $display("FAIL sat i=%0d v=%b c=%0d e=%b exp c=%0d e=%b",
                     i, s_out_valid, s_err_cnt, s_out_err,
                     exp_cnt[i], exp_err[i]);
         end
      end
      s_in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      do_reset();
      push(1'b0, 4'b0000);
      push(1'b0, 4'b1111);
      in_valid = 1'b1;
      in_mode = 1'b0;
      in_data = 4'b0101;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL mid_pre v=%b c=%0d exp 1 1", out_valid, err_cnt);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      model_reset();
      checks++;
      if (out_valid !== 1'b0 || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL mid_rst v=%b c=%0d exp 0 0", out_valid, err_cnt);
      end
      push(1'b0, 4'b0000);
      checks++;
      if (out_err !== 1'b0 || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL mid_first e=%b c=%0d exp 0 0", out_err, err_cnt);
      end
      push(1'b0, 4'b1111);
      checks++;
      if (out_err !== 1'b1 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL mid_flag e=%b c=%0d exp 1 1", out_err, err_cnt);
      end
      push(1'b0, 4'b1111);
      checks++;
      if (out_err !== 1'b0 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL mid_once e=%b c=%0d exp 0 1", out_err, err_cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_mode = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      s_in_valid = 1'b0;
      s_in_mode = 1'b0;
      s_in_data = '0;
      s_out_ready = 1'b1;
      model_reset();
      test_reset();
      test_convert();
      test_streaming();
      test_adjacency();
      test_backpressure();
      test_random_stream();
      test_saturation();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
